lector_sietesegmentos: RTL and testbench

LECTOR_SIETESEGMENTOS -- requirements
Module: lector_sietesegmentos

---
 rtl/lector_pkg.sv | 41 ++++
 rtl/sietesegmentos_inv.sv | 36 +++
 rtl/lector_sietesegmentos.sv | 136 +++++++++++++
 tb/tb_lector_sietesegmentos.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lector_pkg.sv
// Shared constants for the seven-segment reader: segment patterns, digit count,
// default dwell length and small anode helpers.
package lector_pkg;

  localparam int unsigned NDIG              = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 4;

  // Active-low segment patterns, MSB = segment a ... LSB = segment g.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // True when exactly one anode line is driven low.
  function automatic logic an_onehot_low(input logic [NDIG-1:0] a);
    return $onehot(~a);
  endfunction

  // Index of the low anode line; only meaningful when an_onehot_low() holds.
  function automatic logic [1:0] digit_index(input logic [NDIG-1:0] a);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sietesegmentos_inv.sv
// Inverse seven-segment decoder: active-low segment pattern -> hex nibble.
// hit_o is low for any pattern outside the sixteen hex glyphs.
module sietesegmentos_inv
  import lector_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] nibble_o
);

  // Pattern lookup; unknown glyphs fall to the default with hit_o low.
  always_comb begin
    hit_o    = 1'b1;
    nibble_o = 4'h0;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/lector_sietesegmentos.sv
// Seven-segment display reader: watches a multiplexed active-low display bus and
// recovers the hex value shown on each digit once its pattern has dwelt for
// STABLE_CYCLES samples.
// Build option: define LECTOR_SYNC_EN to put a 2-flop synchronizer in front of
// the sampler (latency E+STABLE_CYCLES+3); undefined, the pins feed the sampler
// directly (latency E+STABLE_CYCLES+1).
module lector_sietesegmentos
  import lector_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:6]           SSeg,
  input  logic [NDIG-1:0]      an,
  input  logic                 err_clr,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      valid,
  output logic                 frame_done,
  output logic                 err
);

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
  localparam logic [3:0] StablePre = 4'(STABLE_CYCLES - 1);

  // {an, segments a..g}; segment a lands on bit 6.
  logic [10:0] pins;
  logic [10:0] sample;
  logic [10:0] prev_q;
  assign pins = {an, SSeg};

`ifdef LECTOR_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous display bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end
  assign sample = sync2_q;
`else
  assign sample = pins;
`endif

  logic [3:0] cnt_q, cnt_d;
  logic       cap_q, cap_d;
  logic       sample_ok;

  assign sample_ok = an_onehot_low(sample[10:7]);

  // Dwell counter: restarts on any change or on a blank/multi-select anode
  // pattern; capture fires only on the S-1 -> S step, so once per dwell.
  always_comb begin
    cnt_d = '0;
    cap_d = 1'b0;
    if (sample_ok && (sample == prev_q)) begin
      cap_d = (cnt_q == StablePre);
      cnt_d = (cnt_q == StableMax) ? cnt_q : cnt_q + 4'd1;
    end
  end

  // Previous sample, dwell count and capture strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
      cap_q  <= 1'b0;
    end else begin
      prev_q <= sample;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
    end
  end

  // prev_q still holds the dwelt pattern in the cycle cap_q is high.
  logic       hit;
  logic [3:0] nibble;
  logic [1:0] idx;

  sietesegmentos_inv u_inv (
    .seg_i    (prev_q[6:0]),
    .hit_o    (hit),
    .nibble_o (nibble)
  );

  assign idx = digit_index(prev_q[10:7]);

  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              err_q, err_d;

  // Result update on a capture; err_clr overrides a same-cycle error set.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    frame_d  = 1'b0;
    if (cap_q) begin
      if (hit) begin
        digits_d[{idx, 2'b00} +: 4] = nibble;
        valid_d[idx]                = 1'b1;
        frame_d                     = (idx == 2'(NDIG - 1)) && (&valid_d);
      end else begin
        err_d = 1'b1;
      end
    end
    if (err_clr) err_d = 1'b0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign frame_done = frame_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lector_sietesegmentos.sv
// Directed bench for lector_sietesegmentos with STABLE_CYCLES = 4.
module tb_lector_sietesegmentos;

  localparam int unsigned STABLE = 4;
`ifdef LECTOR_SYNC_EN
  localparam int LAT = STABLE + 3;
`else
  localparam int LAT = STABLE + 1;
`endif

  localparam logic [6:0] P0   = 7'b0000001;
  localparam logic [6:0] P1   = 7'b1001111;
  localparam logic [6:0] P2   = 7'b0010010;
  localparam logic [6:0] P3   = 7'b0000110;
  localparam logic [6:0] P5   = 7'b0100100;
  localparam logic [6:0] P7   = 7'b0001111;
  localparam logic [6:0] P8   = 7'b0000000;
  localparam logic [6:0] PA   = 7'b0001000;
  localparam logic [6:0] PC   = 7'b0110001;
  localparam logic [6:0] PF   = 7'b0111000;
  localparam logic [6:0] PBAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  SSeg;
  logic [3:0]  an;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        frame_done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  lector_sietesegmentos #(
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SSeg       (SSeg),
    .an         (an),
    .err_clr    (err_clr),
    .digits     (digits),
    .valid      (valid),
    .frame_done (frame_done),
    .err        (err)
  );

  // After step(n) the time is 1 unit past the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    an   = a;
    SSeg = s;
  endtask

  task automatic test_reset;
    rst = 1'b0; err_clr = 1'b0;
    drive(4'b1111, PBAD);
    #3;
    n_checks++;
    if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want %h", digits, 16'h0000);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0000) $display("FAIL reset_valid: got %b want %b", valid, 4'b0000);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
    else n_pass++;
    step(3);
    rst = 1'b1;
    step(3);
  endtask

  task automatic test_capture;
    drive(4'b1110, P3);
    step(LAT);
    n_checks++;
    if (digits !== 16'h0000) $display("FAIL capture_early_digits: got %h want %h", digits, 16'h0000);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0000) $display("FAIL capture_early_valid: got %b want %b", valid, 4'b0000);
    else n_pass++;
    step(1);
    n_checks++;
    if (digits[3:0] !== 4'h3) $display("FAIL capture_digit0: got %h want %h", digits[3:0], 4'h3);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0001) $display("FAIL capture_valid: got %b want %b", valid, 4'b0001);
    else n_pass++;
    step(9 - LAT);
    n_checks++;
    if (digits !== 16'h0003) $display("FAIL capture_hold_digits: got %h want %h", digits, 16'h0003);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0001) $display("FAIL capture_hold_valid: got %b want %b", valid, 4'b0001);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL capture_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_scan;
    int fd0;
    fd0 = fd_cnt;
    drive(4'b1110, P1); step(8);
    drive(4'b1101, P2); step(8);
    drive(4'b1011, PA); step(8);
    drive(4'b0111, PF);
    step(LAT);
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL scan_fd_early: got %b want 0", frame_done);
    else n_pass++;
    step(1);
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL scan_fd_pulse: got %b want 1", frame_done);
    else n_pass++;
    n_checks++;
    if (digits !== 16'hFA21) $display("FAIL scan_digits: got %h want %h", digits, 16'hFA21);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1111) $display("FAIL scan_valid: got %b want %b", valid, 4'b1111);
    else n_pass++;
    step(1);
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL scan_fd_single: got %b want 0", frame_done);
    else n_pass++;
    step(4);
    n_checks++;
    if (fd_cnt - fd0 !== 1) $display("FAIL scan_fd_count: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_err;
    drive(4'b1101, PBAD);
    step(LAT);
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_early: got %b want 0", err);
    else n_pass++;
    step(1);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err);
    else n_pass++;
    n_checks++;
    if (digits[7:4] !== 4'h2) $display("FAIL err_digit1: got %h want %h", digits[7:4], 4'h2);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1111) $display("FAIL err_valid: got %b want %b", valid, 4'b1111);
    else n_pass++;
    step(3);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    drive(4'b1111, PBAD); step(3);
    drive(4'b1101, PBAD);
    step(LAT);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clr_priority: got %b want 0", err);
    else n_pass++;
    step(4);
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_after_clr: got %b want 0", err);
    else n_pass++;
    n_checks++;
    if (digits !== 16'hFA21) $display("FAIL err_digits: got %h want %h", digits, 16'hFA21);
    else n_pass++;
  endtask

  task automatic test_glitch;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drive(4'b1011, P8);
      else            drive(4'b1011, P0);
      step(3);
    end
    n_checks++;
    if (digits !== 16'hFA21) $display("FAIL glitch_digits: got %h want %h", digits, 16'hFA21);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1111) $display("FAIL glitch_valid: got %b want %b", valid, 4'b1111);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL glitch_err: got %b want 0", err);
    else n_pass++;
    drive(4'b0000, P7);
    step(12);
    n_checks++;
    if (digits !== 16'hFA21) $display("FAIL multi_an_digits: got %h want %h", digits, 16'hFA21);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1111) $display("FAIL multi_an_valid: got %b want %b", valid, 4'b1111);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL multi_an_err: got %b want 0", err);
    else n_pass++;
    drive(4'b1111, P7);
    step(12);
    n_checks++;
    if (digits !== 16'hFA21) $display("FAIL blank_digits: got %h want %h", digits, 16'hFA21);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1111) $display("FAIL blank_valid: got %b want %b", valid, 4'b1111);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL blank_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    drive(4'b1110, P5);
    step(2);
    rst = 1'b0;
    #1;
    n_checks++;
    if (digits !== 16'h0000) $display("FAIL rmid_digits: got %h want %h", digits, 16'h0000);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0000) $display("FAIL rmid_valid: got %b want %b", valid, 4'b0000);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL rmid_err: got %b want 0", err);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL rmid_fd: got %b want 0", frame_done);
    else n_pass++;
    step(2);
    rst = 1'b1;
    step(LAT);
    n_checks++;
    if (valid !== 4'b0000) $display("FAIL rmid_early_valid: got %b want %b", valid, 4'b0000);
    else n_pass++;
    step(1);
    n_checks++;
    if (digits !== 16'h0005) $display("FAIL rmid_capture_digits: got %h want %h", digits, 16'h0005);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b0001) $display("FAIL rmid_capture_valid: got %b want %b", valid, 4'b0001);
    else n_pass++;
  endtask

  task automatic test_partial_frame;
    int fd0;
    fd0 = fd_cnt;
    drive(4'b0111, PC);
    step(LAT + 1);
    n_checks++;
    if (digits !== 16'hC005) $display("FAIL partial_digits: got %h want %h", digits, 16'hC005);
    else n_pass++;
    n_checks++;
    if (valid !== 4'b1001) $display("FAIL partial_valid: got %b want %b", valid, 4'b1001);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL partial_fd: got %b want 0", frame_done);
    else n_pass++;
    step(3);
    n_checks++;
    if (fd_cnt - fd0 !== 0) $display("FAIL partial_fd_count: got %0d want 0", fd_cnt - fd0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_scan();
    test_err();
    test_glitch();
    test_reset_mid();
    test_partial_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
